cpu_phase_sequencer: RTL and testbench
======================================

# cpu_phase_sequencer

Multi-cycle phase controller that sequences the processor datapath (instruction fetch, regfile read, ALU, dmem access, regfile writeback) from the single system clock. It issues one-cycle enables for the PC, instruction register, regfile write port and dmem write port. It also provides run/step/halt control plus cycle and retired-instruction counters for debug. It sits beside the processor core, inside the skeleton.

## Interface
Parameters:
- CNT_W, 32, width of cycle_count and instr_count
- MEM_WAIT, 1, extra dmem wait cycles after the first MEM cycle (legal 0..3)

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-low; sequencer is in reset while low at a rising edge
- run  in  1  level; high = free-run instructions back to back
- step  in  1  one-cycle pulse; executes exactly one instruction while run is low
- is_mem  in  1  decoded instruction is lw/sw; sampled in DECODE
- is_store  in  1  decoded instruction is sw; sampled in DECODE
- is_halt  in  1  decoded instruction is halt; sampled in DECODE
- rf_wr_req  in  1  decoded instruction writes a register; sampled in DECODE
- phase  out  3  current state encoding
- imem_en  out  1  high in FETCH
- ir_load  out  1  high in FETCH; core latches q_imem into IR at the next edge
- pc_en  out  1  high in WB; core advances PC at the next edge
- rf_we  out  1  high in WB when the latched rf_wr_req is 1 and the latched is_store is 0
- dmem_we  out  1  high only in the first MEM cycle of a store
- busy  out  1  high in FETCH..WB
- halted  out  1  high in HALT
- cycle_count  out  CNT_W  cycles spent in FETCH..WB, saturating
- instr_count  out  CNT_W  retired instructions, saturating

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encoding 7 is illegal and goes to IDLE on the next edge.
- IDLE:
  - Go to FETCH if run=1 or step_pending=1; step_pending clears on this transition.
  - A step pulse seen in IDLE sets step_pending. A step pulse seen in any other state is ignored.
- FETCH -> DECODE, always.
- DECODE:
  - Latch is_mem, is_store, is_halt and rf_wr_req.
  - Go to HALT if is_halt=1, otherwise to EXEC.
- EXEC: go to MEM if latched is_mem=1, otherwise to WB.
- MEM:
  - Stays for 1+MEM_WAIT cycles, counted by a 2-bit wait counter, then goes to WB.
  - dmem_we is asserted only in the first cycle and only for a store.
- WB:
  - pc_en=1; instr_count increments.
  - Go to FETCH if run=1, otherwise to IDLE.
- HALT:
  - Absorbing; only reset leaves it.
  - The halt instruction does not count as retired; PC does not advance.
- run dropping mid-instruction: the current instruction completes through WB, then the sequencer goes to IDLE.
- Counters:
  - cycle_count increments every cycle the state is FETCH..WB.
  - Both counters saturate at all-ones and never wrap.
- Outputs are Moore-decoded from the registered state and latched flags; there is no combinational path from any input to any output.

## Timing
- Reset values: phase=0 (IDLE); imem_en, ir_load, pc_en, rf_we, dmem_we, busy and halted all 0; both counters 0; step_pending 0; latched flags 0.
- Reset low at any edge, including mid-instruction, forces IDLE on that edge; no enable is asserted on the following cycle.
- Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
- Memory instruction: 5+MEM_WAIT cycles.
- Free-run throughput: the FETCH of the next instruction is the cycle after WB.
- step:
  - step pulse in IDLE at edge N: step_pending=1 after N; FETCH begins at edge N+1.
  - run=1 and step together in IDLE: a single FETCH starts and step_pending clears.
- Latched flags hold from DECODE through WB. is_* inputs are don't-care outside DECODE.

## Structure
- Shared package cpu_seq_pkg holds:
  - state localparams (IDLE..HALT, 3-bit)
  - PHASE_W=3
  - the MEM_WAIT legal maximum
- One sub-module: sat_counter (parameter W, inputs clock/reset/inc, output count, saturating), instantiated twice for cycle_count and instr_count.
- The FSM, latched flags, wait counter and step_pending live in the top module.

## Test plan
- Reset: hold reset=0 for 3 edges with run=1 -> phase=0, every enable 0, counters 0. Release reset -> FETCH on the next edge.
- ALU free-run: run=1, three non-memory instructions with rf_wr_req=1 -> phase sequence 1,2,3,5 repeating; rf_we high exactly 3 cycles; instr_count=3 and cycle_count=12 after the third WB.
- Store with MEM_WAIT=1: is_mem=1, is_store=1 -> MEM lasts 2 cycles, dmem_we high 1 cycle only, rf_we=0 in WB, total 6 cycles.
- Step mode: run=0, one step pulse -> exactly one instruction then IDLE, instr_count=1. A second step pulse sent during DECODE is ignored.
- Halt: is_halt=1 in DECODE -> HALT next edge, halted=1, pc_en never asserted, instr_count unchanged. State stays HALT for 20 cycles with run=1 and stays until reset=0.
- Reset mid-MEM: reset=0 during the first MEM cycle of a store -> IDLE at that edge, dmem_we=0 on the following cycle, counters cleared.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_seq_pkg
// Brief    : Shared phase encodings and limits for the CPU phase sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_seq_pkg;

    localparam int PHASE_W      = 3;
    localparam int MEM_WAIT_MAX = 3;

    localparam logic [PHASE_W-1:0] c_IDLE   = 3'd0;
    localparam logic [PHASE_W-1:0] c_FETCH  = 3'd1;
    localparam logic [PHASE_W-1:0] c_DECODE = 3'd2;
    localparam logic [PHASE_W-1:0] c_EXEC   = 3'd3;
    localparam logic [PHASE_W-1:0] c_MEM    = 3'd4;
    localparam logic [PHASE_W-1:0] c_WB     = 3'd5;
    localparam logic [PHASE_W-1:0] c_HALT   = 3'd6;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : W-bit up counter that sticks at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] c_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_count;
    logic [W-1:0] w_count_nxt;

    always_comb begin
        w_count_nxt = r_count;
        if (inc && (r_count != {W{1'b1}})) begin
            w_count_nxt = r_count + c_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/cpu_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_phase_sequencer
// Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB phase controller with
//            run/step/halt control and saturating debug counters.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_phase_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MEM_WAIT = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    input  logic               is_mem,
    input  logic               is_store,
    input  logic               is_halt,
    input  logic               rf_wr_req,
    output logic [PHASE_W-1:0] phase,
    output logic               imem_en,
    output logic               ir_load,
    output logic               pc_en,
    output logic               rf_we,
    output logic               dmem_we,
    output logic               busy,
    output logic               halted,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   instr_count
);

    // Out-of-range MEM_WAIT is clamped so the 2-bit wait counter always terminates.
    localparam int          c_WAIT_INT  = (MEM_WAIT > MEM_WAIT_MAX) ? MEM_WAIT_MAX : MEM_WAIT;
    localparam logic [1:0]  c_WAIT_LAST = 2'(c_WAIT_INT);

    logic [PHASE_W-1:0] r_state,        w_state_nxt;
    logic               r_step_pending, w_step_pending_nxt;
    logic               r_is_mem,       w_is_mem_nxt;
    logic               r_is_store,     w_is_store_nxt;
    logic               r_is_halt,      w_is_halt_nxt;
    logic               r_rf_wr,        w_rf_wr_nxt;
    logic [1:0]         r_wait,         w_wait_nxt;
    logic               w_busy;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state        <= c_IDLE;
            r_step_pending <= 1'b0;
            r_is_mem       <= 1'b0;
            r_is_store     <= 1'b0;
            r_is_halt      <= 1'b0;
            r_rf_wr        <= 1'b0;
            r_wait         <= 2'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_step_pending <= w_step_pending_nxt;
            r_is_mem       <= w_is_mem_nxt;
            r_is_store     <= w_is_store_nxt;
            r_is_halt      <= w_is_halt_nxt;
            r_rf_wr        <= w_rf_wr_nxt;
            r_wait         <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_step_pending_nxt = r_step_pending;
        w_is_mem_nxt       = r_is_mem;
        w_is_store_nxt     = r_is_store;
        w_is_halt_nxt      = r_is_halt;
        w_rf_wr_nxt        = r_rf_wr;
        w_wait_nxt         = 2'd0;

        case (r_state)
            c_IDLE: begin
                // A step only arms here; the FETCH it requests starts one edge later.
                if (run || r_step_pending) begin
                    w_state_nxt        = c_FETCH;
                    w_step_pending_nxt = 1'b0;
                end else if (step) begin
                    w_step_pending_nxt = 1'b1;
                end
            end
            c_FETCH: begin
                w_state_nxt = c_DECODE;
            end
            c_DECODE: begin
                w_is_mem_nxt   = is_mem;
                w_is_store_nxt = is_store;
                w_is_halt_nxt  = is_halt;
                w_rf_wr_nxt    = rf_wr_req;
                w_state_nxt    = is_halt ? c_HALT : c_EXEC;
            end
            c_EXEC: begin
                w_state_nxt = r_is_mem ? c_MEM : c_WB;
            end
            c_MEM: begin
                if (r_wait == c_WAIT_LAST) begin
                    w_state_nxt = c_WB;
                end else begin
                    w_wait_nxt = r_wait + 2'd1;
                end
            end
            c_WB: begin
                w_state_nxt = run ? c_FETCH : c_IDLE;
            end
            c_HALT: begin
                w_state_nxt = c_HALT;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    assign w_busy  = (r_state >= c_FETCH) && (r_state <= c_WB);

    assign phase   = r_state;
    assign imem_en = (r_state == c_FETCH);
    assign ir_load = (r_state == c_FETCH);
    assign pc_en   = (r_state == c_WB);
    assign rf_we   = (r_state == c_WB) && r_rf_wr && !r_is_store;
    assign dmem_we = (r_state == c_MEM) && (r_wait == 2'd0) && r_is_store;
    assign busy    = w_busy;
    assign halted  = (r_state == c_HALT);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (w_busy),
        .count (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (pc_en),
        .count (instr_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_cpu_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_phase_sequencer
// Brief    : Directed plus random checking of cpu_phase_sequencer against an
//            instruction-level phase-plan model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_phase_sequencer;

    localparam int    CNT_W    = 8;
    localparam int    MEM_WAIT = 1;
    localparam longint MAXC    = (64'd1 << CNT_W) - 1;

    logic             clock;
    logic             reset;
    logic             run;
    logic             step;
    logic             is_mem;
    logic             is_store;
    logic             is_halt;
    logic             rf_wr_req;
    logic [2:0]       phase;
    logic             imem_en;
    logic             ir_load;
    logic             pc_en;
    logic             rf_we;
    logic             dmem_we;
    logic             busy;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;

    cpu_phase_sequencer #(.CNT_W(CNT_W), .MEM_WAIT(MEM_WAIT)) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .is_mem      (is_mem),
        .is_store    (is_store),
        .is_halt     (is_halt),
        .rf_wr_req   (rf_wr_req),
        .phase       (phase),
        .imem_en     (imem_en),
        .ir_load     (ir_load),
        .pc_en       (pc_en),
        .rf_we       (rf_we),
        .dmem_we     (dmem_we),
        .busy        (busy),
        .halted      (halted),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Model: current phase plus the queue of phases still to come for the
    // instruction in flight.
    int     m_cur, m_prev;
    int     m_plan[$];
    bit     m_pend, m_store, m_wr;
    longint m_cyc, m_ins;

    // Fields of the instruction presented when the model is in DECODE.
    bit n_mem, n_store, n_halt, n_wr;

    int cnt_rf_we, cnt_dmem_we, cnt_pc_en, cnt_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_edge();
        if (!reset) begin
            m_cur = 0; m_prev = 0; m_plan.delete();
            m_pend = 0; m_store = 0; m_wr = 0;
            m_cyc = 0; m_ins = 0;
            return;
        end
        if (m_cur >= 1 && m_cur <= 5 && m_cyc < MAXC) m_cyc++;
        m_prev = m_cur;
        case (m_cur)
            0: begin
                if (run || m_pend) begin
                    m_cur  = 1;
                    m_pend = 0;
                end else begin
                    m_pend = step;
                end
            end
            1: m_cur = 2;
            2: begin
                m_store = is_store;
                m_wr    = rf_wr_req;
                if (is_halt) begin
                    m_cur = 6;
                end else begin
                    m_plan.delete();
                    if (is_mem) for (int k = 0; k < 1 + MEM_WAIT; k++) m_plan.push_back(4);
                    m_plan.push_back(5);
                    m_cur = 3;
                end
            end
            5: begin
                if (m_ins < MAXC) m_ins++;
                m_cur = run ? 1 : 0;
            end
            6: m_cur = 6;
            default: m_cur = m_plan.pop_front();
        endcase
    endfunction

    task automatic check_all();
        chk("phase",       {61'd0, phase},   m_cur);
        chk("imem_en",     {63'd0, imem_en}, (m_cur == 1));
        chk("ir_load",     {63'd0, ir_load}, (m_cur == 1));
        chk("pc_en",       {63'd0, pc_en},   (m_cur == 5));
        chk("rf_we",       {63'd0, rf_we},   (m_cur == 5 && m_wr && !m_store));
        chk("dmem_we",     {63'd0, dmem_we}, (m_cur == 4 && m_prev == 3 && m_store));
        chk("busy",        {63'd0, busy},    (m_cur >= 1 && m_cur <= 5));
        chk("halted",      {63'd0, halted},  (m_cur == 6));
        chk("cycle_count", {56'd0, cycle_count}, m_cyc);
        chk("instr_count", {56'd0, instr_count}, m_ins);
        cnt_rf_we   += int'(rf_we);
        cnt_dmem_we += int'(dmem_we);
        cnt_pc_en   += int'(pc_en);
        cnt_busy    += int'(busy);
    endtask

    task automatic tick();
        if (m_cur == 2) begin
            is_mem = n_mem; is_store = n_store; is_halt = n_halt; rf_wr_req = n_wr;
        end else begin
            // Don't-care outside DECODE: feed junk.
            is_mem = 1'($urandom); is_store = 1'($urandom);
            is_halt = 1'($urandom); rf_wr_req = 1'($urandom);
        end
        model_edge();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic set_instr(input bit mem, input bit store, input bit halt, input bit wr);
        n_mem = mem; n_store = store; n_halt = halt; n_wr = wr;
    endtask

    task automatic clear_stats();
        cnt_rf_we = 0; cnt_dmem_we = 0; cnt_pc_en = 0; cnt_busy = 0;
    endtask

    initial begin
        longint ins_before;
        m_cur = 0; m_prev = 0; m_pend = 0; m_store = 0; m_wr = 0; m_cyc = 0; m_ins = 0;
        reset = 1'b0; run = 1'b1; step = 1'b0;
        is_mem = 0; is_store = 0; is_halt = 0; rf_wr_req = 0;
        set_instr(0, 0, 0, 1);
        clear_stats();

        // Reset held with run high.
        repeat (3) tick();
        chk("reset_phase", {61'd0, phase}, 64'd0);

        // ALU free-run, three instructions.
        reset = 1'b1;
        clear_stats();
        tick();
        chk("release_fetch", {61'd0, phase}, 64'd1);
        repeat (11) tick();
        run = 1'b0;
        tick();
        chk("alu_rf_we_cycles", cnt_rf_we, 64'd3);
        chk("alu_instr", {56'd0, instr_count}, 64'd3);
        chk("alu_cycles", {56'd0, cycle_count}, 64'd12);
        chk("alu_idle", {61'd0, phase}, 64'd0);

        // Single store with wait state.
        set_instr(1, 1, 0, 1);
        clear_stats();
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 20 && m_cur != 0; i++) tick();
        chk("store_cycles", cnt_busy, 64'd6);
        chk("store_dmem_we", cnt_dmem_we, 64'd1);
        chk("store_rf_we", cnt_rf_we, 64'd0);

        // Step mode; a second step during DECODE is ignored.
        set_instr(0, 0, 0, 1);
        clear_stats();
        ins_before = m_ins;
        step = 1'b1; tick();
        step = 1'b0; tick();
        chk("step_fetch", {61'd0, phase}, 64'd1);
        tick();
        chk("step_decode", {61'd0, phase}, 64'd2);
        step = 1'b1; tick();
        step = 1'b0;
        repeat (8) tick();
        chk("step_one_instr", cnt_pc_en, 64'd1);
        chk("step_instr", {56'd0, instr_count}, ins_before + 1);
        chk("step_idle", {61'd0, phase}, 64'd0);

        // Halt is absorbing with run high.
        set_instr(0, 0, 1, 1);
        clear_stats();
        ins_before = m_ins;
        run = 1'b1;
        repeat (3) tick();
        chk("halt_reached", {61'd0, phase}, 64'd6);
        repeat (20) tick();
        chk("halt_stays", {63'd0, halted}, 64'd1);
        chk("halt_no_pc", cnt_pc_en, 64'd0);
        chk("halt_instr", {56'd0, instr_count}, ins_before);
        reset = 1'b0; tick();
        chk("halt_reset", {61'd0, phase}, 64'd0);

        // Reset during the first MEM cycle of a store.
        reset = 1'b1;
        set_instr(1, 1, 0, 1);
        for (int i = 0; i < 10 && !(m_cur == 4 && m_prev == 3); i++) tick();
        chk("mem_reached", {63'd0, dmem_we}, 64'd1);
        reset = 1'b0; tick();
        chk("mem_reset_phase", {61'd0, phase}, 64'd0);
        chk("mem_reset_cnt", {56'd0, cycle_count}, 64'd0);
        reset = 1'b1; run = 1'b0; tick();
        chk("mem_reset_dmem", {63'd0, dmem_we}, 64'd0);

        // Counter saturation under long free-run.
        set_instr(0, 0, 0, 1);
        run = 1'b1;
        repeat (1100) tick();
        chk("cyc_sat", {56'd0, cycle_count}, MAXC);
        chk("ins_sat", {56'd0, instr_count}, MAXC);

        // Random traffic.
        reset = 1'b0; tick();
        reset = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) run = ~run;
            step = ($urandom_range(0, 7) == 0);
            n_mem   = 1'($urandom);
            n_store = n_mem & 1'($urandom);
            n_halt  = ($urandom_range(0, 29) == 0);
            n_wr    = 1'($urandom);
            reset   = ($urandom_range(0, 149) != 0);
            if (m_cur == 6 && $urandom_range(0, 9) == 0) reset = 1'b0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
